// File: rtl/lpc_io_target_if.sv
// Pin-side and register-side signals of the LPC I/O target, bundled for port connection.
// master = host/peripheral environment, slave = the target engine.
interface lpc_io_target_if #(
  parameter int ADDR_BITS = 3
);
  logic                 lpc_frame;
  logic [3:0]           lpc_ad_in;
  logic [3:0]           lpc_ad_out;
  logic                 lpc_ad_oe;
  logic [ADDR_BITS-1:0] reg_addr;
  logic [7:0]           reg_wdata;
  logic                 reg_wr;
  logic                 reg_rd;
  logic [7:0]           reg_rdata;
  logic                 reg_ready;
  logic                 sync_err;

  modport master (
    output lpc_frame, lpc_ad_in, reg_rdata, reg_ready,
    input  lpc_ad_out, lpc_ad_oe, reg_addr, reg_wdata, reg_wr, reg_rd, sync_err
  );

  modport slave (
    input  lpc_frame, lpc_ad_in, reg_rdata, reg_ready,
    output lpc_ad_out, lpc_ad_oe, reg_addr, reg_wdata, reg_wr, reg_rd, sync_err
  );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes IORD/IOWR for one address window, issues single-strobe
// register accesses and answers with SYNC (wait/ready/error), read data and turnaround.
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h03F8,
  parameter int          ADDR_BITS = 3,
  parameter int          MAX_WAIT  = 16,
  parameter bit          LONG_WAIT = 1'b1
) (
  input  logic           lpc_clk,
  input  logic           lpc_rst,
  lpc_io_target_if.slave bus
);
  localparam logic [3:0] WAIT_NIB = LONG_WAIT ? 4'b0110 : 4'b0101;

  typedef enum logic [3:0] {
    IDLE, CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
    TAR1, TAR2, SYNC, RDLO, RDHI, TTAR
  } state_t;

  state_t               state_reg, state_next;
  logic                 is_wr_reg, is_wr_next;
  logic [11:0]          addr_reg, addr_next;
  logic [3:0]           wlo_reg, wlo_next;
  logic [7:0]           rdata_reg, rdata_next;
  logic [7:0]           wait_reg, wait_next;
  logic [3:0]           ad_out_reg, ad_out_next;
  logic                 oe_reg, oe_next;
  logic                 wr_reg, wr_next;
  logic                 rd_reg, rd_next;
  logic                 err_reg, err_next;
  logic [ADDR_BITS-1:0] raddr_reg, raddr_next;
  logic [7:0]           wdata_reg, wdata_next;
  logic [15:0]          full_addr;
  logic                 hit;

  // Only meaningful in ADDR3, where addr_reg already holds the upper three nibbles.
  assign full_addr = {addr_reg, bus.lpc_ad_in};
  assign hit       = (full_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

  always_comb begin
    state_next  = state_reg;
    is_wr_next  = is_wr_reg;
    addr_next   = addr_reg;
    wlo_next    = wlo_reg;
    rdata_next  = rdata_reg;
    wait_next   = wait_reg;
    raddr_next  = raddr_reg;
    wdata_next  = wdata_reg;
    ad_out_next = 4'hF;
    oe_next     = 1'b0;
    wr_next     = 1'b0;
    rd_next     = 1'b0;
    err_next    = 1'b0;

    // LFRAME# low restarts (START) or aborts any cycle in progress.
    if (!bus.lpc_frame && (state_reg != IDLE || bus.lpc_ad_in == 4'h0)) begin
      state_next = (bus.lpc_ad_in == 4'h0) ? CTDIR : IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        CTDIR: begin
          wait_next  = 8'd0;
          is_wr_next = (bus.lpc_ad_in == 4'b0010);
          state_next = (bus.lpc_ad_in == 4'b0000 || bus.lpc_ad_in == 4'b0010) ? ADDR0 : IDLE;
        end
        ADDR0: begin
          addr_next  = {addr_reg[7:0], bus.lpc_ad_in};
          state_next = ADDR1;
        end
        ADDR1: begin
          addr_next  = {addr_reg[7:0], bus.lpc_ad_in};
          state_next = ADDR2;
        end
        ADDR2: begin
          addr_next  = {addr_reg[7:0], bus.lpc_ad_in};
          state_next = ADDR3;
        end
        ADDR3: begin
          if (hit) begin
            raddr_next = full_addr[ADDR_BITS-1:0];
            rd_next    = !is_wr_reg;
            state_next = is_wr_reg ? WDATA0 : TAR1;
          end else begin
            state_next = IDLE;
          end
        end
        WDATA0: begin
          wlo_next   = bus.lpc_ad_in;
          state_next = WDATA1;
        end
        WDATA1: begin
          wdata_next = {bus.lpc_ad_in, wlo_reg};
          wr_next    = 1'b1;
          state_next = TAR1;
        end
        TAR1: state_next = TAR2;
        TAR2, SYNC: begin
          oe_next = 1'b1;
          if (bus.reg_ready) begin
            ad_out_next = 4'b0000;
            if (!is_wr_reg) rdata_next = bus.reg_rdata;
            state_next = is_wr_reg ? TTAR : RDLO;
          end else if (wait_reg == 8'(MAX_WAIT)) begin
            ad_out_next = 4'b1010;
            err_next    = 1'b1;
            if (!is_wr_reg) rdata_next = 8'hFF;
            state_next = is_wr_reg ? TTAR : RDLO;
          end else begin
            ad_out_next = WAIT_NIB;
            wait_next   = wait_reg + 8'd1;
            state_next  = SYNC;
          end
        end
        RDLO: begin
          oe_next     = 1'b1;
          ad_out_next = rdata_reg[3:0];
          state_next  = RDHI;
        end
        RDHI: begin
          oe_next     = 1'b1;
          ad_out_next = rdata_reg[7:4];
          state_next  = TTAR;
        end
        TTAR: begin
          oe_next     = 1'b1;
          ad_out_next = 4'hF;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      state_reg  <= IDLE;
      is_wr_reg  <= 1'b0;
      addr_reg   <= '0;
      wlo_reg    <= '0;
      rdata_reg  <= '0;
      wait_reg   <= '0;
      ad_out_reg <= 4'hF;
      oe_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      rd_reg     <= 1'b0;
      err_reg    <= 1'b0;
      raddr_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      is_wr_reg  <= is_wr_next;
      addr_reg   <= addr_next;
      wlo_reg    <= wlo_next;
      rdata_reg  <= rdata_next;
      wait_reg   <= wait_next;
      ad_out_reg <= ad_out_next;
      oe_reg     <= oe_next;
      wr_reg     <= wr_next;
      rd_reg     <= rd_next;
      err_reg    <= err_next;
      raddr_reg  <= raddr_next;
      wdata_reg  <= wdata_next;
    end
  end

  assign bus.lpc_ad_out = ad_out_reg;
  assign bus.lpc_ad_oe  = oe_reg;
  assign bus.reg_addr   = raddr_reg;
  assign bus.reg_wdata  = wdata_reg;
  assign bus.reg_wr     = wr_reg;
  assign bus.reg_rd     = rd_reg;
  assign bus.sync_err   = err_reg;
endmodule

// File: tb/tb_lpc_io_target.sv
// Bench for lpc_io_target: acts as LPC host and register peripheral, predicting the target's
// LAD response per edge from the transaction parameters.
module tb_lpc_io_target;
  localparam logic [15:0] BASE     = 16'h03F8;
  localparam int          AB       = 3;
  localparam int          MAXW     = 16;
  localparam logic [3:0]  WNIB     = 4'b0110;
  localparam logic [5:0]  IDLE_OUT = {1'b0, 4'hF, 1'b0};

  logic lpc_clk = 1'b0;
  logic lpc_rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [AB-1:0] rd_addr_seen = '0, wr_addr_seen = '0;
  logic [7:0] wdata_seen = '0;

  lpc_io_target_if #(.ADDR_BITS(AB)) bus ();

  lpc_io_target #(
    .BASE_ADDR(BASE), .ADDR_BITS(AB), .MAX_WAIT(MAXW), .LONG_WAIT(1'b1)
  ) dut (
    .lpc_clk(lpc_clk),
    .lpc_rst(lpc_rst),
    .bus(bus)
  );

  always #5 lpc_clk = ~lpc_clk;

  // Strobe monitor: counts pulses so repeated or overlapping strobes show up.
  always @(negedge lpc_clk) begin
    if (bus.reg_rd) begin
      rd_cnt++;
      rd_addr_seen = bus.reg_addr;
    end
    if (bus.reg_wr) begin
      wr_cnt++;
      wr_addr_seen = bus.reg_addr;
      wdata_seen   = bus.reg_wdata;
    end
    if (bus.reg_rd && bus.reg_wr) both_cnt++;
  end

  function automatic logic [5:0] outs();
    return {bus.lpc_ad_oe, bus.lpc_ad_out, bus.sync_err};
  endfunction

  function automatic logic [18:0] regs();
    return {bus.lpc_ad_oe, bus.lpc_ad_out, bus.reg_wr, bus.reg_rd, bus.sync_err,
            bus.reg_addr, bus.reg_wdata};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic frame, input logic [3:0] ad, input logic rdy,
                      input logic [7:0] rdata, input logic [5:0] exp, input string tag);
    @(negedge lpc_clk);
    bus.lpc_frame = frame;
    bus.lpc_ad_in = ad;
    bus.reg_ready = rdy;
    bus.reg_rdata = rdata;
    @(posedge lpc_clk);
    #1;
    check(tag, 32'(outs()), 32'(exp));
  endtask

  // One host cycle. abort_at: host-cycle index replaced by LFRAME# low (no START), -1 none.
  // rst_k: SYNC-phase edge index after which reset is pulsed, -1 none.
  task automatic run_io(input string tag, input logic [3:0] ct, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd, input int delay,
                        input int nstart, input int abort_at, input int rst_k);
    logic [4:0] hq[$];
    logic [5:0] seq[$];
    logic [7:0] dout;
    logic       rdy;
    logic [7:0] rdat;
    logic [5:0] exp;
    bit is_wr, decoded, err, did_rst;
    int waits, k, rd0, wr0, n;

    is_wr   = (ct == 4'h2);
    decoded = (ct == 4'h0 || ct == 4'h2) && (addr[15:AB] == BASE[15:AB]) && (abort_at < 0);
    waits   = (delay < MAXW) ? delay : MAXW;
    err     = (delay > MAXW);
    dout    = err ? 8'hFF : rd;
    did_rst = 1'b0;

    for (int s = 0; s < nstart; s++) hq.push_back({1'b0, 4'h0});
    hq.push_back({1'b1, ct});
    for (int b = 3; b >= 0; b--) hq.push_back({1'b1, addr[b*4 +: 4]});
    if (is_wr) begin
      hq.push_back({1'b1, wd[3:0]});
      hq.push_back({1'b1, wd[7:4]});
    end
    hq.push_back({1'b1, 4'hF});
    hq.push_back({1'b1, 4'hF});
    if (abort_at >= 0) begin
      while (hq.size() > abort_at) void'(hq.pop_back());
      hq.push_back({1'b0, 4'hF});
    end

    if (decoded) begin
      for (int j = 0; j < waits; j++) seq.push_back({1'b1, WNIB, 1'b0});
      seq.push_back({1'b1, err ? 4'hA : 4'h0, err});
      if (!is_wr) begin
        seq.push_back({1'b1, dout[3:0], 1'b0});
        seq.push_back({1'b1, dout[7:4], 1'b0});
      end
      seq.push_back({1'b1, 4'hF, 1'b0});
      seq.push_back(IDLE_OUT);
    end else begin
      for (int j = 0; j < 4; j++) seq.push_back(IDLE_OUT);
    end

    $display("txn %s ct=%h addr=%h wd=%h rd=%h delay=%0d decoded=%0d", tag, ct, addr, wd, rd,
             delay, decoded);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    n   = hq.size();
    k   = decoded ? -(n - 1) : -1000;

    for (int i = 0; i < n; i++) begin
      rdy  = (k >= 0 && k <= waits) ? (k >= delay) : 1'($urandom_range(0, 1));
      rdat = (k == waits) ? rd : 8'($urandom);
      exp  = (i == n - 1 && decoded) ? seq.pop_front() : IDLE_OUT;
      step(hq[i][4], hq[i][3:0], rdy, rdat, exp, $sformatf("%s host%0d", tag, i));
      k++;
    end
    while (seq.size() > 0 && !did_rst) begin
      rdy  = (k >= 0 && k <= waits) ? (k >= delay) : 1'($urandom_range(0, 1));
      rdat = (k == waits) ? rd : 8'($urandom);
      step(1'b1, 4'hF, rdy, rdat, seq.pop_front(), $sformatf("%s k%0d", tag, k));
      if (k == rst_k) begin
        #2 lpc_rst = 1'b1;
        #1;
        check({tag, " async reset"}, 32'(regs()), 32'({1'b0, 4'hF, 3'b000, 3'b000, 8'h00}));
        @(negedge lpc_clk);
        lpc_rst = 1'b0;
        did_rst = 1'b1;
      end
      k++;
    end

    check({tag, " rd pulses"}, 32'(rd_cnt - rd0), 32'(decoded && !is_wr));
    check({tag, " wr pulses"}, 32'(wr_cnt - wr0), 32'(decoded && is_wr));
    if (decoded && !is_wr) check({tag, " rd addr"}, 32'(rd_addr_seen), 32'(addr[AB-1:0]));
    if (decoded && is_wr) begin
      check({tag, " wr addr"}, 32'(wr_addr_seen), 32'(addr[AB-1:0]));
      check({tag, " wdata"}, 32'(wdata_seen), 32'(wd));
    end
  endtask

  initial begin
    bus.lpc_frame = 1'b1;
    bus.lpc_ad_in = 4'hF;
    bus.reg_ready = 1'b0;
    bus.reg_rdata = 8'h00;
    repeat (3) @(posedge lpc_clk);
    #1;
    check("reset state", 32'(regs()), 32'({1'b0, 4'hF, 3'b000, 3'b000, 8'h00}));
    @(negedge lpc_clk);
    lpc_rst = 1'b0;

    run_io("iord_3fd",      4'h0, 16'h03FD, 8'h00, 8'h60, 0,   1, -1, -1);
    run_io("iowr_3f8",      4'h2, 16'h03F8, 8'h5A, 8'h00, 0,   1, -1, -1);
    run_io("memrd_2f8",     4'h4, 16'h02F8, 8'h00, 8'h33, 0,   1, -1, -1);
    run_io("iord_miss_2f8", 4'h0, 16'h02F8, 8'h00, 8'h33, 0,   1, -1, -1);
    run_io("iord_wait3",    4'h0, 16'h03F8, 8'h00, 8'h9C, 3,   1, -1, -1);
    run_io("iord_timeout",  4'h0, 16'h03FB, 8'h12, 8'h12, 100, 1, -1, -1);
    run_io("iowr_timeout",  4'h2, 16'h03F9, 8'h3C, 8'h00, 40,  1, -1, -1);
    run_io("iord_wait16",   4'h0, 16'h03FF, 8'h00, 8'hE1, 16,  1, -1, -1);
    run_io("double_start",  4'h0, 16'h03FE, 8'h00, 8'hC3, 1,   2, -1, -1);
    run_io("abort_addr2",   4'h2, 16'h03FC, 8'h77, 8'h00, 0,   1, 4,  -1);
    run_io("iord_after_ab", 4'h0, 16'h03FD, 8'h00, 8'h60, 0,   1, -1, -1);
    run_io("rst_in_sync",   4'h0, 16'h03FA, 8'h00, 8'h44, 100, 1, -1, 3);
    run_io("iowr_after_rst",4'h2, 16'h03FF, 8'hA5, 8'h00, 1,   1, -1, -1);

    for (int t = 0; t < 24; t++) begin
      logic [3:0]  ct;
      logic [15:0] a;
      int          dly;
      case ($urandom_range(0, 4))
        0, 1:    ct = 4'h0;
        2, 3:    ct = 4'h2;
        default: ct = 4'($urandom);
      endcase
      a   = ($urandom_range(0, 3) != 0) ? (BASE | 16'($urandom_range(0, 7))) : 16'($urandom);
      dly = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
      run_io($sformatf("rand%0d", t), ct, a, 8'($urandom), 8'($urandom), dly,
             $urandom_range(1, 2), -1, -1);
    end

    check("no rd/wr overlap", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
